// File: rtl/temple_mem_pkg.sv
// Shared types and constants for the Temple memory subsystem.
package temple_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  // The high byte of a word at this address would fall outside the memory.
  localparam logic [ADDR_W-1:0] BAD_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two-port memory arbiter; one-hot grant out.
module mem_arb_pick
  import temple_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_state_t state_i,
  input  logic       last_i,
  input  logic       lock_lim_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (state_i)
      OWN0: begin
        // The owner keeps the port unless the other side has waited out the lock budget.
        if (req_i[0] && !(req_i[1] && lock_lim_i)) gnt_o = 2'b01;
        else if (req_i[1])                         gnt_o = 2'b10;
      end
      OWN1: begin
        if (req_i[1] && !(req_i[0] && lock_lim_i)) gnt_o = 2'b10;
        else if (req_i[0])                         gnt_o = 2'b01;
      end
      default: begin
        if (&req_i) gnt_o = last_i ? 2'b01 : 2'b10;
        else        gnt_o = req_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded lock between the core (port 0) and the host loader (port 1).
module mem_arbiter
  import temple_mem_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic              lock0_i,
  input  logic              lock1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_rw_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned LcntW = $clog2(MAX_LOCK + 1);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic [LcntW-1:0]  lcnt_q, lcnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0]        pick_gnt;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              lock_lim;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic              w_lock;
  logic              bad;
  arb_state_t        own_st;

  assign lock_lim = (lcnt_q == LcntW'(MAX_LOCK));

  mem_arb_pick u_pick (
    .req_i      ({req1_i, req0_i}),
    .state_i    (state_q),
    .last_i     (last_q),
    .lock_lim_i (lock_lim),
    .gnt_o      (pick_gnt)
  );

  // Grants are gated while reset is low so no memory write can slip through.
  assign gnt     = rst_ni ? pick_gnt : 2'b00;
  assign any_gnt = |gnt;
  assign gnt0_o  = gnt[0];
  assign gnt1_o  = gnt[1];

  assign w_addr  = gnt[1] ? addr1_i  : addr0_i;
  assign w_wdata = gnt[1] ? wdata1_i : wdata0_i;
  assign w_we    = gnt[1] ? we1_i    : we0_i;
  assign w_lock  = gnt[1] ? lock1_i  : lock0_i;
  assign bad     = (w_addr == BAD_ADDR);
  assign own_st  = gnt[1] ? OWN1 : OWN0;

  assign mem_addr_o  = any_gnt ? w_addr  : '0;
  assign mem_wdata_o = any_gnt ? w_wdata : '0;
  assign mem_rw_o    = any_gnt & w_we & ~bad;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    lcnt_d  = lcnt_q;
    if (any_gnt) begin
      last_d = gnt[1];
      if (w_lock) begin
        state_d = own_st;
        if (state_q != own_st) lcnt_d = LcntW'(1);
        else if (!lock_lim)    lcnt_d = lcnt_q + LcntW'(1);
      end else begin
        state_d = IDLE;
        lcnt_d  = '0;
      end
    end else if ((state_q == OWN0 && !lock0_i) || (state_q == OWN1 && !lock1_i)) begin
      state_d = IDLE;
      lcnt_d  = '0;
    end
  end

  always_comb begin
    rvalid_d = gnt & ~{we1_i, we0_i};
    err_d    = bad ? gnt : 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (rvalid_d[0]) rdata0_d = bad ? '0 : mem_rdata_i;
    if (rvalid_d[1]) rdata1_d = bad ? '0 : mem_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      lcnt_q   <= '0;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      lcnt_q   <= lcnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign rvalid0_o = rvalid_q[0];
  assign rvalid1_o = rvalid_q[1];
  assign err0_o    = err_q[0];
  assign err1_o    = err_q[1];
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle compare against a behavioural model plus literal checks.
module tb_mem_arbiter;

  localparam int MaxLock = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_rw;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata, mem_addr_p1;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_LOCK(MaxLock)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req0_i      (req0),
    .req1_i      (req1),
    .we0_i       (we0),
    .we1_i       (we1),
    .lock0_i     (lock0),
    .lock1_i     (lock1),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .rvalid0_o   (rvalid0),
    .rvalid1_o   (rvalid1),
    .rdata0_o    (rdata0),
    .rdata1_o    (rdata1),
    .err0_o      (err0),
    .err1_o      (err1),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rw_o    (mem_rw),
    .mem_rdata_i (mem_rdata)
  );

  // Byte-wide memory seen by the DUT.
  bit [7:0] mem [0:65535];
  assign mem_addr_p1 = mem_addr + 16'd1;
  assign mem_rdata   = {mem[mem_addr_p1], mem[mem_addr]};
  always @(posedge clk) begin
    if (mem_rw) begin
      mem[mem_addr]    <= mem_wdata[7:0];
      mem[mem_addr_p1] <= mem_wdata[15:8];
    end
  end

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner (-1 none), last grant, lock count, reference memory.
  bit [7:0]    mm [0:65535];
  int          m_owner = -1;
  int          m_last  = 1;
  int          m_lcnt  = 0;
  bit [1:0]    m_rv, m_err;
  logic [15:0] m_rd [2];

  function automatic logic p_req(input int i);   return i == 0 ? req0   : req1;   endfunction
  function automatic logic p_we(input int i);    return i == 0 ? we0    : we1;    endfunction
  function automatic logic p_lock(input int i);  return i == 0 ? lock0  : lock1;  endfunction
  function automatic logic [15:0] p_addr(input int i);  return i == 0 ? addr0  : addr1;  endfunction
  function automatic logic [15:0] p_wdata(input int i); return i == 0 ? wdata0 : wdata1; endfunction

  function automatic int m_winner();
    int o;
    if (!rst_ni) return -1;
    if (m_owner < 0) begin
      if (req0 && req1) return 1 - m_last;
      if (req0) return 0;
      if (req1) return 1;
      return -1;
    end
    o = 1 - m_owner;
    if (p_req(m_owner) && !(p_req(o) && m_lcnt == MaxLock)) return m_owner;
    if (p_req(o)) return o;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    int          w;
    logic [15:0] a;
    if (!rst_ni) begin
      m_owner = -1; m_last = 1; m_lcnt = 0;
      m_rv = 2'b00; m_err = 2'b00; m_rd[0] = 16'h0; m_rd[1] = 16'h0;
    end else begin
      w = m_winner();
      m_rv = 2'b00; m_err = 2'b00;
      if (w >= 0) begin
        a = p_addr(w);
        m_err[w] = (a == 16'hFFFF);
        if (!p_we(w)) begin
          m_rv[w] = 1'b1;
          m_rd[w] = (a == 16'hFFFF) ? 16'h0 : {mm[a + 16'd1], mm[a]};
        end else if (a != 16'hFFFF) begin
          mm[a] = p_wdata(w)[7:0];
          mm[a + 16'd1] = p_wdata(w)[15:8];
        end
        if (p_lock(w)) begin
          m_lcnt  = (m_owner == w) ? ((m_lcnt < MaxLock) ? m_lcnt + 1 : m_lcnt) : 1;
          m_owner = w;
        end else begin
          m_owner = -1; m_lcnt = 0;
        end
        m_last = w;
      end else if (m_owner >= 0 && !p_lock(m_owner)) begin
        m_owner = -1; m_lcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    if (chk_en) begin
      w = m_winner();
      chk("gnt0", 16'(gnt0), 16'(w == 0));
      chk("gnt1", 16'(gnt1), 16'(w == 1));
      chk("mem_rw", 16'(mem_rw), 16'(w >= 0 && p_we(w) && p_addr(w) != 16'hFFFF));
      chk("mem_addr", mem_addr, (w >= 0) ? p_addr(w) : 16'h0);
      chk("mem_wdata", mem_wdata, (w >= 0) ? p_wdata(w) : 16'h0);
      chk("rvalid0", 16'(rvalid0), 16'(m_rv[0]));
      chk("rvalid1", 16'(rvalid1), 16'(m_rv[1]));
      chk("err0", 16'(err0), 16'(m_err[0]));
      chk("err1", 16'(err1), 16'(m_err[1]));
      chk("rdata0", rdata0, m_rd[0]);
      chk("rdata1", rdata1, m_rd[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [15:0] a, input logic [15:0] v);
    mem[a] <= v[7:0];
    mem[a + 16'd1] <= v[15:8];
    mm[a] = v[7:0];
    mm[a + 16'd1] = v[15:8];
  endtask

  initial begin
    rst_ni = 1'b0;
    {req0, req1, we0, we1, lock0, lock1} = '0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
    set_word(16'd1000, 16'd9);
    set_word(16'd1002, 16'd8);
    mem[16'hFFFF] <= 8'hA5; mm[16'hFFFF] = 8'hA5;
    mem[16'h0000] <= 8'h5A; mm[16'h0000] = 8'h5A;

    // Reset held with both ports writing.
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 16'd2000; addr1 = 16'd2002; wdata0 = 16'h1111; wdata1 = 16'h2222;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt0", 16'(gnt0), 16'd0);
    chk("rst_gnt1", 16'(gnt1), 16'd0);
    chk("rst_rw", 16'(mem_rw), 16'd0);
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("first_gnt0", 16'(gnt0), 16'd1);
    tick();
    @(negedge clk);
    chk("second_gnt1", 16'(gnt1), 16'd1);
    tick();
    {req0, req1, we0, we1} = '0;

    // Contention: alternating reads.
    addr0 = 16'd1000; addr1 = 16'd1002; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_gnt0", 16'(gnt0), 16'(i % 2 == 0));
      if (i % 2 == 1) begin
        chk("alt_rvalid0", 16'(rvalid0), 16'd1);
        chk("alt_rdata0", rdata0, 16'd9);
      end else if (i > 0) begin
        chk("alt_rvalid1", 16'(rvalid1), 16'd1);
        chk("alt_rdata1", rdata1, 16'd8);
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("alt_rdata1_end", rdata1, 16'd8);

    // Write from port 1, read back on port 0.
    tick();
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'd1010; wdata1 = 16'hABCD;
    @(negedge clk);
    chk("wr_gnt1", 16'(gnt1), 16'd1);
    tick();
    req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; addr0 = 16'd1010;
    @(negedge clk);
    chk("rd_gnt0", 16'(gnt0), 16'd1);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("rd_rvalid0", 16'(rvalid0), 16'd1);
    chk("rd_rdata0", rdata0, 16'hABCD);

    // Point last at port 1, then a locked port 0 contends with port 1.
    req1 = 1'b1; addr1 = 16'd1002;
    tick();
    req1 = 1'b0;
    tick();
    req0 = 1'b1; lock0 = 1'b1; addr0 = 16'd1000; req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lock_gnt0", 16'(gnt0), 16'(i < 4));
      chk("lock_gnt1", 16'(gnt1), 16'(i == 4));
      tick();
    end
    {req0, req1, lock0} = '0;
    tick();

    // Rejected address: write then read of 16'hFFFF.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'hFFFF; wdata0 = 16'h1234;
    @(negedge clk);
    chk("bad_wr_gnt0", 16'(gnt0), 16'd1);
    chk("bad_wr_rw", 16'(mem_rw), 16'd0);
    tick();
    we0 = 1'b0;
    @(negedge clk);
    chk("bad_wr_err0", 16'(err0), 16'd1);
    chk("bad_wr_mem_ffff", 16'(mem[16'hFFFF]), 16'h00A5);
    chk("bad_wr_mem_0000", 16'(mem[16'h0000]), 16'h005A);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("bad_rd_rdata0", rdata0, 16'h0);
    chk("bad_rd_err0", 16'(err0), 16'd1);
    chk("bad_rd_rvalid0", 16'(rvalid0), 16'd1);
    tick();

    // Reset while port 1 owns the lock.
    req1 = 1'b1; lock1 = 1'b1; addr1 = 16'd1002;
    @(negedge clk);
    chk("own1_gnt1", 16'(gnt1), 16'd1);
    tick();
    rst_ni = 1'b0;
    req0 = 1'b1; addr0 = 16'd1000;
    #1;
    chk("mrst_rvalid1", 16'(rvalid1), 16'd0);
    chk("mrst_gnt1", 16'(gnt1), 16'd0);
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("mrst_gnt0", 16'(gnt0), 16'd1);
    chk("mrst_no_gnt1", 16'(gnt1), 16'd0);
    tick();
    {req0, req1, lock1} = '0;
    tick();
    tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port, byte-addressed 16-bit memory between the Temple core (port 0) and a host/DMA loader (port 1). It selects one requester per cycle with round-robin fairness, drives the memory's address, write-data and write-enable, and returns registered read data with fixed one-cycle latency. A lock input keeps ownership across back-to-back accesses, such as read-modify-write sequences. The lock is bounded by a starvation counter.

## Interface
- ADDR_W, 16, address width (byte address).
- DATA_W, 16, data width. Each word occupies bytes addr (low) and addr+1 (high).
- MAX_LOCK, 4, maximum consecutive locked grants to one port while the other port is requesting.

- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- req0, req1  in  1  access request; held until the matching gnt is seen.
- we0, we1  in  1  1 = write, 0 = read; valid with req.
- lock0, lock1  in  1  keep ownership after this access.
- addr0, addr1  in  ADDR_W  byte address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  combinational; the access completes at the posedge where req&gnt=1.
- rvalid0, rvalid1  out  1  registered one-cycle pulse; rdata is valid.
- rdata0, rdata1  out  DATA_W  registered read data; holds its value until the next read by that port.
- err0, err1  out  1  registered one-cycle pulse for a rejected access.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory wdata.
- mem_rw  out  1  to memory rw (1 = write at posedge, 0 = read).
- mem_rdata  in  DATA_W  combinational read data from memory.

## Operation
- State machine states:
  - IDLE: no owner.
  - OWN0: port 0 holds the lock.
  - OWN1: port 1 holds the lock.
- Also held in registers: a last-grant pointer `last` (reset 1, so port 0 wins the first tie) and a lock counter `lcnt`, width clog2(MAX_LOCK+1).
- Selection in IDLE:
  - A single requester wins.
  - If both request, the port != `last` wins.
- Selection in OWNn:
  - Port n wins if it requests, unless the other port requests and `lcnt` == MAX_LOCK. In that case the other port wins.
  - If port n does not request and the other port does, the other port wins.
- On a granted access (posedge):
  - `last` <= the granted port.
  - If the winner's lock=1, next state is OWN(winner) and `lcnt` <= (same owner ? `lcnt`+1 : 1).
  - If lock=0, next state is IDLE and `lcnt` <= 0.
- With no grant, the state holds OWNn only if lock_n is still 1; otherwise it goes to IDLE.
- Memory drive:
  - mem_addr and mem_wdata follow the winner.
  - mem_rw = winner's we.
  - With no winner: mem_addr=0, mem_wdata=0, mem_rw=0.
- Read: on a granted read, rdata_n <= mem_rdata at the posedge, and rvalid_n = 1 for the following cycle.
- Address 16'hFFFF is rejected, because its high byte falls outside the memory:
  - The request is granted (the handshake completes).
  - mem_rw is forced to 0.
  - For a read, rdata_n <= 0 and rvalid_n is pulsed.
  - err_n is pulsed in all cases.
- Odd addresses are legal and are passed through unchanged.

## Timing
- Reset values (while rst=0, asynchronously):
  - state=IDLE, last=1, lcnt=0.
  - rvalid*=0, err*=0, rdata*=0.
  - gnt*=0 and mem_rw=0, forced; no memory write can occur during reset.
- Grant latency: 0 cycles (same cycle as req) when the port is selected.
- Write lands in memory at the grant posedge.
- Read data is available 1 cycle after the grant, on rvalid.
- Sustained throughput: one access per cycle; alternating ports under contention when lock=0.
- Simultaneous events:
  - Both ports requesting in IDLE resolves via `last`.
  - The owner dropping lock and req in the same cycle the other port requests gives a same-cycle grant to the other port.
- A requester may change addr, we or wdata only after its gnt.
- Reset asserted mid-lock: ownership is lost and the access in flight is discarded.

## Structure
- Shared package temple_mem_pkg holds:
  - arb_state_t enum {IDLE, OWN0, OWN1}.
  - ADDR_W and DATA_W constants.
  - BAD_ADDR = 16'hFFFF.
- One sub-module, mem_arb_pick: combinational winner select from req, state, last and lock-limit, outputting a one-hot grant.
- Register bank and muxing stay in mem_arbiter.

## Test plan
- Reset: hold rst=0 with req0=req1=1, we=1 -> gnt*=0, mem_rw=0; after release, the first grant goes to port 0.
- Contention: req0/req1 continuous reads of 1000/1002, lock=0 -> grants alternate 0,1,0,1; rdata0=9, rdata1=8, each one cycle after its grant.
- Write-then-read: port 1 writes 16'hABCD to 1010, then port 0 reads 1010 -> rvalid0 next cycle with rdata0=16'hABCD.
- Lock limit: lock0=1, req0 continuous, req1 raised, MAX_LOCK=4 -> port 0 receives 4 consecutive grants after req1 rises, then gnt1 in the next cycle.
- Bad address: port 0 writes 16'h1234 to 16'hFFFF -> gnt0=1, mem_rw=0, err0 pulses, memory unchanged; a read of 16'hFFFF gives rdata0=0 with err0 and rvalid0.
- Mid-lock reset: port 1 in OWN1, pulse rst=0 -> state=IDLE, rvalid1=0; after release, req0 is granted immediately.
